// File: rtl/multimode_ff_bank_pkg.sv
// ffb_pkg: shared types, default widths and the per-bit next-state helper
// for the multimode flip-flop bank.
// Optional feature macro: FFB_ERR_CNT_EN (enables the illegal-event counter).
package ffb_pkg;

  // Default number of flop bits in a bank
  localparam int FFB_WIDTH_DEF = 8;
  // Default width of the optional illegal-event counter
  localparam int FFB_CNT_W_DEF = 8;

  // Run-time flop type selected for the whole bank
  typedef enum logic [1:0] {
    FFB_D  = 2'b00,
    FFB_T  = 2'b01,
    FFB_JK = 2'b10,
    FFB_SR = 2'b11
  } ffb_mode_e;

  // Next state of one enabled flop bit. An SR=11 request holds, so an
  // illegal input can never turn into an unknown value.
  function automatic logic ffb_next_bit(input ffb_mode_e mode,
                                        input logic      q,
                                        input logic      a,
                                        input logic      b);
    logic nxt;
    nxt = q;
    case (mode)
      FFB_D:  nxt = a;
      FFB_T:  nxt = a ? ~q : q;
      FFB_JK: begin
        case ({a, b})
          2'b00:   nxt = q;
          2'b01:   nxt = 1'b0;
          2'b10:   nxt = 1'b1;
          2'b11:   nxt = ~q;
          default: nxt = q;
        endcase
      end
      FFB_SR: begin
        case ({a, b})
          2'b00:   nxt = q;
          2'b01:   nxt = 1'b0;
          2'b10:   nxt = 1'b1;
          2'b11:   nxt = q;
          default: nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multimode_ff_bank_if.sv
// multimode_ff_bank_if: control/data bundle between a bank user (master)
// and the flop bank (slave). err_cnt exists only when FFB_ERR_CNT_EN is defined.
interface multimode_ff_bank_if
  import ffb_pkg::*;
#(
  parameter int WIDTH = FFB_WIDTH_DEF
`ifdef FFB_ERR_CNT_EN
  ,
  parameter int CNT_W = FFB_CNT_W_DEF
`endif
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  ffb_mode_e        mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             sr_err;
  logic             sr_err_sticky;
`ifdef FFB_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt;
`endif

`ifdef FFB_ERR_CNT_EN
  modport master (
    output en, load, load_val, mode, a, b, clr_err,
    input  q, q_bar, sr_err, sr_err_sticky, err_cnt
  );
  modport slave (
    input  en, load, load_val, mode, a, b, clr_err,
    output q, q_bar, sr_err, sr_err_sticky, err_cnt
  );
`else
  modport master (
    output en, load, load_val, mode, a, b, clr_err,
    input  q, q_bar, sr_err, sr_err_sticky
  );
  modport slave (
    input  en, load, load_val, mode, a, b, clr_err,
    output q, q_bar, sr_err, sr_err_sticky
  );
`endif

endinterface

// File: rtl/multimode_ff_bank_bit.sv
// ffb_bit: one flop of the bank with its own next-state mux. Flags an
// illegal SR=11 request on the current edge so the top can OR-reduce it.
module ffb_bit
  import ffb_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  logic      load,
  input  logic      load_bit,
  input  ffb_mode_e mode,
  input  logic      a,
  input  logic      b,
  output logic      q,
  output logic      illegal
);

  logic q_d;
  logic q_q;

  // Next state: parallel load beats the enable; disabled bits hold
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_bit;
    end else if (en) begin
      q_d = ffb_next_bit(mode, q_q, a, b);
    end else begin
      q_d = q_q;
    end
  end

  // State flop with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= RST_BIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q       = q_q;
  assign illegal = en & ~load & (mode == FFB_SR) & a & b;

endmodule

// File: rtl/multimode_ff_bank.sv
// multimode_ff_bank: WIDTH-bit register whose flop type (D/T/JK/SR) is chosen
// at run time. SR=11 holds and raises a one-edge sr_err pulse plus a sticky flag.
// Optional feature macro: FFB_ERR_CNT_EN adds a saturating illegal-event
// counter (err_cnt); without it the counter and its port are absent.
module multimode_ff_bank
  import ffb_pkg::*;
#(
  parameter int               WIDTH   = FFB_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = '0
`ifdef FFB_ERR_CNT_EN
  ,
  parameter int               CNT_W   = FFB_CNT_W_DEF
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  multimode_ff_bank_if.slave    ffb
);

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] illegal_s;
  logic             sr_err_set_s;

  logic sr_err_d;
  logic sr_err_q;
  logic sticky_d;
  logic sticky_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ffb_bit #(
      .RST_BIT (RST_VAL[i])
    ) u_bit (
      .clk      (clk),
      .rst      (rst),
      .en       (ffb.en),
      .load     (ffb.load),
      .load_bit (ffb.load_val[i]),
      .mode     (ffb.mode),
      .a        (ffb.a[i]),
      .b        (ffb.b[i]),
      .q        (q_s[i]),
      .illegal  (illegal_s[i])
    );
  end

  // One event per edge no matter how many bits saw SR=11
  assign sr_err_set_s = |illegal_s;

  // Error flags next state: a new illegal event wins over clr_err
  always_comb begin
    sr_err_d = sr_err_set_s;
    sticky_d = sticky_q;
    if (sr_err_set_s) begin
      sticky_d = 1'b1;
    end else if (ffb.clr_err) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Error flag flops with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_err_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      sr_err_q <= sr_err_d;
      sticky_q <= sticky_d;
    end
  end

`ifdef FFB_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] err_cnt_d;
  logic [CNT_W-1:0] err_cnt_q;

  // Counter next state: clr_err restarts the count, keeping this edge's event
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (ffb.clr_err) begin
      if (sr_err_set_s) begin
        err_cnt_d = CNT_ONE;
      end else begin
        err_cnt_d = '0;
      end
    end else if (sr_err_set_s && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_ONE;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Saturating counter flop with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ffb.err_cnt = err_cnt_q;
`endif

  assign ffb.q             = q_s;
  assign ffb.q_bar         = ~q_s;
  assign ffb.sr_err        = sr_err_q;
  assign ffb.sr_err_sticky = sticky_q;

endmodule
